// File: rtl/mtr_pkg.sv
// Shared types and helpers for the motor duty scheduler.
package mtr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } mtr_state_t;

  localparam logic [10:0] DUTY_MID = 11'h400;

  // Clamp a signed speed to +/-max and re-centre it on DUTY_MID (offset binary).
  function automatic logic [10:0] sat_to_duty(input logic signed [11:0] spd, input int max);
    int s;
    s = int'(spd);
    if (s > max) s = max;
    else if (s < -max) s = -max;
    return 11'(s + int'(DUTY_MID));
  endfunction

endpackage

// File: rtl/duty_slew.sv
// One duty register: forced to mid-scale or stepped toward its target on synch.
// Slew limiting is compiled in with MTR_SLEW_LIMIT_EN; otherwise the target is taken directly.
module duty_slew
  import mtr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        synch,
  input  logic        force_mid,
  input  logic [10:0] target,
  input  logic [10:0] step,
  output logic [10:0] duty
);

  logic [10:0] duty_nxt;

`ifdef MTR_SLEW_LIMIT_EN
  logic        up;
  logic [10:0] gap;
  logic [10:0] move;

  assign up   = (target >= duty);
  assign gap  = up ? (target - duty) : (duty - target);
  assign move = (gap > step) ? step : gap;
  assign duty_nxt = up ? (duty + move) : (duty - move);
`else
  logic unused_step;

  assign unused_step = ^step;
  assign duty_nxt    = target;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= DUTY_MID;
    end else if (force_mid) begin
      duty <= DUTY_MID;
    end else if (synch) begin
      duty <= duty_nxt;
    end
  end

endmodule

// File: rtl/mtr_duty_sched.sv
// Converts speed commands to PWM duties applied on PWM_synch and supervises over-current.
// Optional slew limiting of the duty updates is enabled by defining MTR_SLEW_LIMIT_EN.
module mtr_duty_sched
  import mtr_pkg::*;
#(
  parameter int MAX_SPD       = 900,
  parameter int SLEW_STEP     = 64,
  parameter int FAULT_PERIODS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic signed [11:0] lft_spd,
  input  logic signed [11:0] rght_spd,
  input  logic               spd_vld,
  output logic               spd_rdy,
  input  logic               PWM_synch,
  input  logic               OVR_I_blank_n,
  input  logic               OVR_I_lft,
  input  logic               OVR_I_rght,
  input  logic               clr_fault,
  output logic [10:0]        lft_duty,
  output logic [10:0]        rght_duty,
  output logic               OVR_I_shtdwn
);

  localparam int CNT_W = $clog2(FAULT_PERIODS + 1);

  mtr_state_t       state, state_nxt;
  logic [10:0]      lft_tgt, rght_tgt;
  logic             period_flag;
  logic [CNT_W-1:0] oc_cnt, cnt_nxt;
  logic             sample, hit, trip, accept;
  logic             force_mid, run_synch;

  assign sample = (OVR_I_lft | OVR_I_rght) & OVR_I_blank_n;
  assign hit    = period_flag | sample;
  assign accept = spd_vld & spd_rdy;

  always_comb begin
    cnt_nxt = '0;
    if (hit) begin
      cnt_nxt = (oc_cnt < CNT_W'(FAULT_PERIODS)) ? oc_cnt + 1'b1 : oc_cnt;
    end
  end

  assign trip = (state == RUN) & PWM_synch & hit & (cnt_nxt == CNT_W'(FAULT_PERIODS));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN: begin
        if (trip)     state_nxt = FAULT;
        else if (!en) state_nxt = IDLE;
      end
      FAULT:   if (clr_fault) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      spd_rdy      <= 1'b0;
      OVR_I_shtdwn <= 1'b0;
    end else begin
      state        <= state_nxt;
      spd_rdy      <= (state_nxt == RUN);
      OVR_I_shtdwn <= (state_nxt == FAULT);
    end
  end

  // The flag gathers events across the period; the synch cycle's own sample counts too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_flag <= 1'b0;
      oc_cnt      <= '0;
    end else if (state != RUN) begin
      period_flag <= 1'b0;
      oc_cnt      <= '0;
    end else if (PWM_synch) begin
      period_flag <= 1'b0;
      oc_cnt      <= cnt_nxt;
    end else begin
      period_flag <= hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_tgt  <= DUTY_MID;
      rght_tgt <= DUTY_MID;
    end else if ((state == RUN) && (state_nxt == IDLE)) begin
      lft_tgt  <= DUTY_MID;
      rght_tgt <= DUTY_MID;
    end else if (accept) begin
      lft_tgt  <= sat_to_duty(lft_spd, MAX_SPD);
      rght_tgt <= sat_to_duty(rght_spd, MAX_SPD);
    end
  end

  // Fault forcing is immediate (including the tripping synch); idle forcing waits for synch.
  assign force_mid = (state_nxt == FAULT) | (state == FAULT) | ((state == IDLE) & PWM_synch);
  assign run_synch = PWM_synch & (state == RUN);

  duty_slew u_slew_lft (
    .clk       (clk),
    .rst_n     (rst_n),
    .synch     (run_synch),
    .force_mid (force_mid),
    .target    (lft_tgt),
    .step      (11'(SLEW_STEP)),
    .duty      (lft_duty)
  );

  duty_slew u_slew_rght (
    .clk       (clk),
    .rst_n     (rst_n),
    .synch     (run_synch),
    .force_mid (force_mid),
    .target    (rght_tgt),
    .step      (11'(SLEW_STEP)),
    .duty      (rght_duty)
  );

endmodule

// File: tb/tb_mtr_duty_sched.sv
// Self-checking bench for mtr_duty_sched: directed steps plus random periods against a reference model.
module tb_mtr_duty_sched;

`ifdef MTR_SLEW_LIMIT_EN
  localparam int STEP = 64;
`else
  localparam int STEP = 1 << 12;
`endif
  localparam int FP  = 8;
  localparam int MID = 1024;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic signed [11:0] lft_spd = '0;
  logic signed [11:0] rght_spd = '0;
  logic               spd_vld = 1'b0;
  logic               spd_rdy;
  logic               PWM_synch = 1'b0;
  logic               OVR_I_blank_n = 1'b0;
  logic               OVR_I_lft = 1'b0;
  logic               OVR_I_rght = 1'b0;
  logic               clr_fault = 1'b0;
  logic [10:0]        lft_duty;
  logic [10:0]        rght_duty;
  logic               OVR_I_shtdwn;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: mode 0 idle, 1 run, 2 fault
  int m_mode, m_tl, m_tr, m_dl, m_dr, m_cnt;
  bit m_flag, m_shut;

  mtr_duty_sched dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .lft_spd       (lft_spd),
    .rght_spd      (rght_spd),
    .spd_vld       (spd_vld),
    .spd_rdy       (spd_rdy),
    .PWM_synch     (PWM_synch),
    .OVR_I_blank_n (OVR_I_blank_n),
    .OVR_I_lft     (OVR_I_lft),
    .OVR_I_rght    (OVR_I_rght),
    .clr_fault     (clr_fault),
    .lft_duty      (lft_duty),
    .rght_duty     (rght_duty),
    .OVR_I_shtdwn  (OVR_I_shtdwn)
  );

  always #5 clk = ~clk;

  function automatic int sat(input logic signed [11:0] s);
    int v;
    v = s;
    if (v > 900) v = 900;
    if (v < -900) v = -900;
    return MID + v;
  endfunction

  function automatic int toward(input int d, input int t);
    int g;
    g = t - d;
    if (g > STEP) g = STEP;
    if (g < -STEP) g = -STEP;
    return d + g;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_tl = MID; m_tr = MID; m_dl = MID; m_dr = MID;
    m_cnt = 0; m_flag = 0; m_shut = 0;
  endtask

  task automatic model_update();
    bit s, hits;
    s = (OVR_I_lft || OVR_I_rght) && OVR_I_blank_n;
    case (m_mode)
      0: begin
        if (PWM_synch) begin m_dl = MID; m_dr = MID; end
        m_cnt = 0; m_flag = 0;
        if (en) m_mode = 1;
      end
      1: begin
        if (PWM_synch) begin
          hits  = m_flag || s;
          m_dl  = toward(m_dl, m_tl);
          m_dr  = toward(m_dr, m_tr);
          m_cnt = hits ? ((m_cnt + 1 > FP) ? FP : m_cnt + 1) : 0;
          m_flag = 0;
        end else begin
          m_flag = m_flag || s;
        end
        if (spd_vld) begin m_tl = sat(lft_spd); m_tr = sat(rght_spd); end
        if (m_cnt == FP) begin
          m_mode = 2; m_shut = 1; m_dl = MID; m_dr = MID; m_cnt = 0; m_flag = 0;
        end else if (!en) begin
          m_mode = 0; m_tl = MID; m_tr = MID; m_cnt = 0; m_flag = 0;
        end
      end
      default: begin
        if (clr_fault) begin m_mode = 0; m_shut = 0; end
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    model_update();
    @(posedge clk);
    #1;
    chk({tag, "_lduty"}, 32'(lft_duty), 32'(m_dl));
    chk({tag, "_rduty"}, 32'(rght_duty), 32'(m_dr));
    chk({tag, "_shtdwn"}, 32'(OVR_I_shtdwn), 32'(m_shut));
    chk({tag, "_rdy"}, 32'(spd_rdy), 32'(m_mode == 1));
  endtask

  task automatic send(input logic signed [11:0] l, input logic signed [11:0] r, input string tag);
    lft_spd = l; rght_spd = r; spd_vld = 1'b1;
    tick(tag);
    spd_vld = 1'b0;
  endtask

  // One PWM period; over-current pulse (if any) lands on the second cycle.
  task automatic period(input int len, input bit ovl, input bit ovr, input bit blank, input string tag);
    for (int i = 0; i < len; i++) begin
      PWM_synch     = (i == len - 1);
      OVR_I_lft     = ovl && (i == 1);
      OVR_I_rght    = ovr && (i == 1);
      OVR_I_blank_n = blank;
      tick(tag);
    end
    PWM_synch = 1'b0; OVR_I_lft = 1'b0; OVR_I_rght = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_lduty", 32'(lft_duty), 32'h400);
    chk("reset_rduty", 32'(rght_duty), 32'h400);
    chk("reset_shtdwn", 32'(OVR_I_shtdwn), 32'h0);
    chk("reset_rdy", 32'(spd_rdy), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic ramp +200 / -200
    en = 1'b1;
    tick("enable");
    send(12'sd200, -12'sd200, "send200");
    tick("pre_synch");
    chk("pre_synch_const", 32'(lft_duty), 32'h400);
    period(8, 0, 0, 1, "ramp1");
`ifdef MTR_SLEW_LIMIT_EN
    chk("ramp1_l_const", 32'(lft_duty), 32'h440);
    chk("ramp1_r_const", 32'(rght_duty), 32'h3C0);
    repeat (3) period(8, 0, 0, 1, "ramp");
`endif
    chk("ramp_l_final", 32'(lft_duty), 32'h4C8);
    chk("ramp_r_final", 32'(rght_duty), 32'h338);

    // Saturation at both extremes
    send(12'sh7FF, 12'sh800, "sat");
    repeat (16) period(6, 0, 0, 1, "sat_ramp");
    chk("sat_l_const", 32'(lft_duty), 32'h784);
    chk("sat_r_const", 32'(rght_duty), 32'h07C);

    // Events while blanked are ignored
    repeat (10) period(6, 1, 1, 0, "blanked");
    chk("blanked_noflt", 32'(OVR_I_shtdwn), 32'h0);

    // Eight consecutive offending periods trip the fault
    repeat (FP) period(6, 1, 0, 1, "trip");
    chk("trip_shtdwn", 32'(OVR_I_shtdwn), 32'h1);
    chk("trip_lduty", 32'(lft_duty), 32'h400);
    tick("fault_hold");

    // Clear wins over a simultaneous new event; en still high re-enters RUN
    clr_fault = 1'b1; OVR_I_rght = 1'b1; OVR_I_blank_n = 1'b1;
    tick("clr");
    clr_fault = 1'b0; OVR_I_rght = 1'b0;
    chk("clr_shtdwn", 32'(OVR_I_shtdwn), 32'h0);
    tick("rerun");
    chk("rerun_rdy", 32'(spd_rdy), 32'h1);

    // Seven offending, one clean, seven offending: no trip
    repeat (FP - 1) period(5, 1, 0, 1, "seq_a");
    period(5, 0, 0, 1, "seq_clean");
    repeat (FP - 1) period(5, 0, 1, 1, "seq_b");
    chk("seq_noflt", 32'(OVR_I_shtdwn), 32'h0);
    period(5, 0, 0, 1, "seq_flush");

    // Accept coinciding with synch: old target for this update
    send(12'sd100, 12'sd100, "pre_coinc");
    period(5, 0, 0, 1, "pre_coinc_p");
    repeat (3) tick("gap");
    lft_spd = -12'sd300; rght_spd = 12'sd300; spd_vld = 1'b1; PWM_synch = 1'b1;
    tick("coinc");
    spd_vld = 1'b0; PWM_synch = 1'b0;
    period(5, 0, 0, 1, "coinc_next");

    // Dropping en mid-ramp forces mid-scale at the next synch
    send(12'sd800, -12'sd800, "big");
    period(5, 0, 0, 1, "big_p");
    en = 1'b0;
    tick("en_drop");
    period(5, 0, 0, 1, "idle_p");
    chk("idle_l_const", 32'(lft_duty), 32'h400);
    chk("idle_r_const", 32'(rght_duty), 32'h400);
    en = 1'b1;
    tick("re_en");

    // Random periods
    for (int p = 0; p < 60; p++) begin
      en = ($urandom_range(0, 15) != 0);
      clr_fault = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1)
        send(12'($urandom), 12'($urandom), "rnd_send");
      clr_fault = 1'b0;
      period($urandom_range(4, 10), ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 4) != 0), "rnd");
    end

    // Asynchronous reset in the middle of a period
    en = 1'b1;
    send(12'sd500, 12'sd500, "pre_rst");
    period(5, 0, 0, 1, "pre_rst_p");
    tick("mid");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_lduty", 32'(lft_duty), 32'h400);
    chk("arst_rduty", 32'(rght_duty), 32'h400);
    chk("arst_rdy", 32'(spd_rdy), 32'h0);
    chk("arst_shtdwn", 32'(OVR_I_shtdwn), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    tick("post_rst");
    period(5, 0, 0, 1, "post_rst_p");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
